// File: rtl/pc_pkg.sv
// pc_pkg: shared state type, defaults and alignment helper
// for the program-counter unit and its return-address stack.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HOLD
  } pc_state_t;

  localparam int XLEN_D        = 32;
  localparam int INSTR_BYTES_D = 4;
  localparam int RAS_DEPTH_D   = 4;

  function automatic int alb(input int bytes);
    return $clog2(bytes);
  endfunction

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; a push when full
// silently overwrites the oldest entry.
module pc_ras
  import pc_pkg::*;
#(
  parameter int XLEN  = XLEN_D,
  parameter int DEPTH = RAS_DEPTH_D
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic            replace,
  input  logic [XLEN-1:0] din,
  output logic [XLEN-1:0] top,
  output logic            empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] mem [DEPTH];
  logic [PW-1:0]   wp;
  logic [PW-1:0]   tp;
  logic [PW-1:0]   wp_inc;
  logic [CW-1:0]   cnt;
  logic            full;

  // wp is the next free slot, tp the live top
  assign tp = (wp == '0) ? PW'(DEPTH - 1)
                         : wp - PW'(1);
  assign wp_inc = (wp == PW'(DEPTH - 1)) ? '0
                                         : wp + PW'(1);

  assign top   = mem[tp];
  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (replace) begin
      mem[tp] <= din;
    end else if (push) begin
      mem[wp] <= din;
      wp      <= wp_inc;
      if (!full) begin
        cnt <= cnt + CW'(1);
      end
    end else if (pop && !empty) begin
      wp  <= tp;
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch-address generator with stall, redirect/flush
// and fetch handshake; optional return-address stack under PC_RAS_EN.
module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = XLEN_D,
  parameter int              INSTR_BYTES  = INSTR_BYTES_D,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              RAS_DEPTH    = RAS_DEPTH_D
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            fetch_ready,
`ifdef PC_RAS_EN
  input  logic            call_i,
  input  logic            ret_i,
  output logic            ras_empty,
`endif
  output logic            pc_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_prev,
  output logic            pc_prev_valid,
  output logic            misalign_err
);

  localparam int ALB = alb(INSTR_BYTES);
  localparam logic [XLEN-1:0] MASK =
    ~({XLEN{1'b1}} << ALB);

  pc_state_t       state;
  pc_state_t       state_n;
  logic            accept;
  logic [XLEN-1:0] seq;
  logic [XLEN-1:0] acc_pc;
  logic [XLEN-1:0] pc_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= BOOT;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    if (!redirect_valid && state == BOOT) begin
      state_n = RUN;
    end else begin
      state_n = stall ? HOLD : RUN;
    end
  end

  always_comb begin
    pc_valid = (state == RUN);
  end

  assign accept = pc_valid & fetch_ready & ~redirect_valid;
  assign seq    = pc + XLEN'(INSTR_BYTES);

`ifdef PC_RAS_EN
  logic            ret_hit;
  logic [XLEN-1:0] ras_top;

  assign ret_hit = ret_i & ~ras_empty;
  assign acc_pc  = ret_hit ? ras_top : seq;

  pc_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .rst_n   (reset),
    .push    (accept & call_i & ~ret_hit),
    .pop     (accept & ret_hit & ~call_i),
    .replace (accept & ret_hit & call_i),
    .din     (seq),
    .top     (ras_top),
    .empty   (ras_empty)
  );
`else
  assign acc_pc = seq;

  // depth only matters when the stack is built
  if (RAS_DEPTH < 0) begin : g_no_ras
  end
`endif

  always_comb begin
    pc_n = pc;
    if (redirect_valid) begin
      pc_n = redirect_target & ~MASK;
    end else if (accept) begin
      pc_n = acc_pc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc            <= RESET_VECTOR;
      pc_prev       <= RESET_VECTOR;
      pc_prev_valid <= 1'b0;
      misalign_err  <= 1'b0;
    end else begin
      pc           <= pc_n;
      misalign_err <= redirect_valid &
                      (|(redirect_target & MASK));
      if (redirect_valid) begin
        pc_prev_valid <= 1'b0;
      end else if (accept) begin
        pc_prev       <= pc;
        pc_prev_valid <= 1'b1;
      end
    end
  end

endmodule
